// File: rtl/dac_spi_scheduler.sv
// Boot-table sequencer and two-requester round-robin arbiter for the shared
// DAC SPI command bus; exactly one driver command is in flight at a time.
module dac_spi_scheduler #(
  parameter int BOOT_DLY = 1024,
  parameter int CMD_WAIT = 64,
  parameter int NUM_INIT = 4,
  parameter logic [NUM_INIT*32-1:0] INIT_TABLE = {NUM_INIT{32'h0000_0000}}
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req0_in,
  input  logic        req1_in,
  input  logic [15:0] addr0_in,
  input  logic [15:0] addr1_in,
  input  logic [15:0] data0_in,
  input  logic [15:0] data1_in,
  input  logic        sel0_in,
  input  logic        sel1_in,
  output logic        gnt0_out,
  output logic        gnt1_out,
  output logic        done0_out,
  output logic        done1_out,
  output logic [15:0] rdata0_out,
  output logic [15:0] rdata1_out,
  output logic        dac0_trig_out,
  output logic        dac1_trig_out,
  output logic [15:0] cmd_addr_out,
  output logic [15:0] cmd_data_out,
  input  logic [15:0] dac0_rdata_in,
  input  logic [15:0] dac1_rdata_in,
  output logic        init_done_out,
  output logic        busy_out
);

  localparam int CNT_MAX = (BOOT_DLY > CMD_WAIT) ? BOOT_DLY : CMD_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(2 * NUM_INIT + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DLY - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CMD_WAIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * NUM_INIT - 1);
  localparam logic [IDX_W-1:0] IDX_DAC1  = IDX_W'(NUM_INIT);

  typedef enum logic [2:0] {
    S_BOOT, S_INIT_ISSUE, S_INIT_WAIT, S_ARB, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             rr_reg, rr_next;
  logic             owner_reg, owner_next;
  logic             sel_reg, sel_next;
  logic [15:0]      cmd_addr_reg, cmd_addr_next;
  logic [15:0]      cmd_data_reg, cmd_data_next;
  logic [15:0]      rdata0_reg, rdata0_next;
  logic [15:0]      rdata1_reg, rdata1_next;
  logic             init_done_reg, init_done_next;

  logic [31:0]      init_entry [NUM_INIT];
  logic [IDX_W-1:0] load_idx, load_tbl_idx;
  logic [31:0]      load_entry;
  logic             load_boot;
  logic             pick;

  generate
    for (genvar gi = 0; gi < NUM_INIT; gi++) begin : g_tbl
      assign init_entry[gi] = INIT_TABLE[32*gi +: 32];
    end
  endgenerate

  // Entry for the next INIT_ISSUE: 0 when leaving BOOT, else the following index.
  always_comb begin
    load_idx     = (state_reg == S_BOOT) ? '0 : idx_reg + IDX_W'(1);
    load_tbl_idx = (load_idx >= IDX_DAC1) ? load_idx - IDX_DAC1 : load_idx;
    load_entry   = '0;
    for (int i = 0; i < NUM_INIT; i++) begin
      if (load_tbl_idx == IDX_W'(i)) load_entry = init_entry[i];
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = '0;
    idx_next       = idx_reg;
    rr_next        = rr_reg;
    owner_next     = owner_reg;
    sel_next       = sel_reg;
    cmd_addr_next  = cmd_addr_reg;
    cmd_data_next  = cmd_data_reg;
    rdata0_next    = rdata0_reg;
    rdata1_next    = rdata1_reg;
    init_done_next = init_done_reg;
    load_boot      = 1'b0;
    pick           = 1'b0;
    case (state_reg)
      S_BOOT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == BOOT_LAST) begin
          cnt_next   = '0;
          load_boot  = 1'b1;
          state_next = S_INIT_ISSUE;
        end
      end
      S_INIT_ISSUE: state_next = S_INIT_WAIT;
      S_INIT_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == WAIT_LAST) begin
          cnt_next = '0;
          idx_next = idx_reg + IDX_W'(1);
          if (idx_reg == IDX_LAST) begin
            init_done_next = 1'b1;
            state_next     = S_ARB;
          end else begin
            load_boot  = 1'b1;
            state_next = S_INIT_ISSUE;
          end
        end
      end
      S_ARB: begin
        if (req0_in || req1_in) begin
          // With both pending the pointer decides; a lone request always wins.
          pick = (req0_in && req1_in) ? rr_reg : req1_in;
          if (req0_in && req1_in) rr_next = ~rr_reg;
          owner_next    = pick;
          sel_next      = pick ? sel1_in  : sel0_in;
          cmd_addr_next = pick ? addr1_in : addr0_in;
          cmd_data_next = pick ? data1_in : data0_in;
          state_next    = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == WAIT_LAST) begin
          cnt_next = '0;
          if (owner_reg) rdata1_next = sel_reg ? dac1_rdata_in : dac0_rdata_in;
          else           rdata0_next = sel_reg ? dac1_rdata_in : dac0_rdata_in;
          state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_ARB;
      default: state_next = S_BOOT;
    endcase
    if (load_boot) begin
      sel_next      = (load_idx >= IDX_DAC1);
      cmd_addr_next = load_entry[31:16];
      cmd_data_next = load_entry[15:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= S_BOOT;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      rr_reg        <= 1'b0;
      owner_reg     <= 1'b0;
      sel_reg       <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_data_reg  <= '0;
      rdata0_reg    <= '0;
      rdata1_reg    <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      rr_reg        <= rr_next;
      owner_reg     <= owner_next;
      sel_reg       <= sel_next;
      cmd_addr_reg  <= cmd_addr_next;
      cmd_data_reg  <= cmd_data_next;
      rdata0_reg    <= rdata0_next;
      rdata1_reg    <= rdata1_next;
      init_done_reg <= init_done_next;
    end
  end

  // Strobes decode straight from registered state, so they are clean one-cycle pulses.
  assign dac0_trig_out = ((state_reg == S_INIT_ISSUE) || (state_reg == S_ISSUE)) && !sel_reg;
  assign dac1_trig_out = ((state_reg == S_INIT_ISSUE) || (state_reg == S_ISSUE)) &&  sel_reg;
  assign gnt0_out      = (state_reg == S_ISSUE) && !owner_reg;
  assign gnt1_out      = (state_reg == S_ISSUE) &&  owner_reg;
  assign done0_out     = (state_reg == S_DONE)  && !owner_reg;
  assign done1_out     = (state_reg == S_DONE)  &&  owner_reg;
  assign busy_out      = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
  assign cmd_addr_out  = cmd_addr_reg;
  assign cmd_data_out  = cmd_data_reg;
  assign rdata0_out    = rdata0_reg;
  assign rdata1_out    = rdata1_reg;
  assign init_done_out = init_done_reg;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Scoreboard bench: stimulus pushes expected triggers/completions, a monitor
// sampling 1 time unit after each rising edge pops and compares them.
module tb_dac_spi_scheduler;

  localparam int BOOT_DLY = 8;
  localparam int CMD_WAIT = 4;
  localparam int NUM_INIT = 2;
  localparam logic [63:0] TABLE = {32'h0002_00A5, 32'h0001_0010};

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        req0_in = 1'b0, req1_in = 1'b0;
  logic [15:0] addr0_in = '0, addr1_in = '0, data0_in = '0, data1_in = '0;
  logic        sel0_in = 1'b0, sel1_in = 1'b0;
  logic [15:0] dac0_rdata_in = '0, dac1_rdata_in = '0;
  logic        gnt0_out, gnt1_out, done0_out, done1_out;
  logic [15:0] rdata0_out, rdata1_out, cmd_addr_out, cmd_data_out;
  logic        dac0_trig_out, dac1_trig_out, init_done_out, busy_out;

  dac_spi_scheduler #(
    .BOOT_DLY(BOOT_DLY), .CMD_WAIT(CMD_WAIT), .NUM_INIT(NUM_INIT), .INIT_TABLE(TABLE)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_in(req0_in), .req1_in(req1_in),
    .addr0_in(addr0_in), .addr1_in(addr1_in),
    .data0_in(data0_in), .data1_in(data1_in),
    .sel0_in(sel0_in), .sel1_in(sel1_in),
    .gnt0_out(gnt0_out), .gnt1_out(gnt1_out),
    .done0_out(done0_out), .done1_out(done1_out),
    .rdata0_out(rdata0_out), .rdata1_out(rdata1_out),
    .dac0_trig_out(dac0_trig_out), .dac1_trig_out(dac1_trig_out),
    .cmd_addr_out(cmd_addr_out), .cmd_data_out(cmd_data_out),
    .dac0_rdata_in(dac0_rdata_in), .dac1_rdata_in(dac1_rdata_in),
    .init_done_out(init_done_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic        dac;
    logic [15:0] addr;
    logic [15:0] data;
  } trig_t;

  typedef struct {
    int          cyc;
    logic        who;
    logic [15:0] rdata;
  } done_t;

  trig_t trig_q[$];
  done_t done_q[$];
  int    init_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_beg = -1;
  int busy_end = -1;
  logic init_prev = 1'b0;

  logic [15:0] boot_addr [2] = '{16'h0001, 16'h0002};
  logic [15:0] boot_data [2] = '{16'h0010, 16'h00A5};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_trig(input int c, input logic [1:0] g, input logic d,
                           input logic [15:0] a, input logic [15:0] v);
    trig_t t;
    t.cyc = c; t.gnt = g; t.dac = d; t.addr = a; t.data = v;
    trig_q.push_back(t);
  endtask

  task automatic push_done(input int c, input logic w, input logic [15:0] r);
    done_t e;
    e.cyc = c; e.who = w; e.rdata = r;
    done_q.push_back(e);
  endtask

  // Called at a falling edge: one reset edge, then expect the full boot replay.
  // Cycle numbering: the sample after reset edge t0 is boot cycle 1.
  task automatic do_reset();
    rst_in = 1'b1;
    @(negedge clk_in);
    t0 = cyc;
    rst_in = 1'b0;
    check("rst_ctl", 64'({dac0_trig_out, dac1_trig_out, gnt0_out, gnt1_out,
                          done0_out, done1_out, busy_out, init_done_out}), 64'd0);
    check("rst_cmd", 64'({cmd_addr_out, cmd_data_out}), 64'd0);
    check("rst_rdata", 64'({rdata0_out, rdata1_out}), 64'd0);
    for (int i = 0; i < 2 * NUM_INIT; i++)
      push_trig(t0 + BOOT_DLY + i * (CMD_WAIT + 1), 2'b00, (i >= NUM_INIT),
                boot_addr[i % NUM_INIT], boot_data[i % NUM_INIT]);
    init_q.push_back(t0 + BOOT_DLY + 2 * NUM_INIT * (CMD_WAIT + 1));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
      #1;
      if (rst_in) busy_end = -1;
      while (trig_q.size() > 0 && trig_q[0].cyc < cyc) begin
        check("trig_late", 64'(cyc), 64'(trig_q[0].cyc));
        void'(trig_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        check("done_late", 64'(cyc), 64'(done_q[0].cyc));
        void'(done_q.pop_front());
      end
      while (init_q.size() > 0 && init_q[0] < cyc) begin
        check("init_late", 64'(cyc), 64'(init_q[0]));
        void'(init_q.pop_front());
      end
      if (dac0_trig_out || dac1_trig_out) begin
        $display("trig cyc=%0d dac0=%b dac1=%b gnt=%b%b addr=%h data=%h",
                 cyc - t0 + 1, dac0_trig_out, dac1_trig_out, gnt1_out, gnt0_out,
                 cmd_addr_out, cmd_data_out);
        if (trig_q.size() == 0) begin
          check("trig_unexp", 64'({dac1_trig_out, dac0_trig_out}), 64'd0);
        end else begin
          trig_t t;
          t = trig_q.pop_front();
          check("trig_cyc", 64'(cyc), 64'(t.cyc));
          check("trig_dac", 64'({dac1_trig_out, dac0_trig_out}), t.dac ? 64'd2 : 64'd1);
          check("trig_gnt", 64'({gnt1_out, gnt0_out}), 64'(t.gnt));
          check("cmd_addr", 64'(cmd_addr_out), 64'(t.addr));
          check("cmd_data", 64'(cmd_data_out), 64'(t.data));
          if (t.gnt != 2'b00) begin
            busy_beg = cyc;
            busy_end = cyc + CMD_WAIT;
          end
        end
      end else begin
        check("gnt_idle", 64'({gnt1_out, gnt0_out}), 64'd0);
      end
      check("busy", 64'(busy_out), 64'(cyc >= busy_beg && cyc <= busy_end));
      if (done0_out || done1_out) begin
        $display("done cyc=%0d done=%b%b rdata0=%h rdata1=%h",
                 cyc - t0 + 1, done1_out, done0_out, rdata0_out, rdata1_out);
        if (done_q.size() == 0) begin
          check("done_unexp", 64'({done1_out, done0_out}), 64'd0);
        end else begin
          done_t e;
          e = done_q.pop_front();
          check("done_cyc", 64'(cyc), 64'(e.cyc));
          check("done_who", 64'({done1_out, done0_out}), e.who ? 64'd2 : 64'd1);
          check("done_rdata", 64'(e.who ? rdata1_out : rdata0_out), 64'(e.rdata));
        end
      end
      if (init_done_out && !init_prev) begin
        $display("init_done cyc=%0d", cyc - t0 + 1);
        if (init_q.size() == 0) begin
          check("init_unexp", 64'(init_done_out), 64'd0);
        end else begin
          check("init_cyc", 64'(cyc), 64'(init_q.pop_front()));
        end
      end
      init_prev = init_done_out;
    end
  end

  // Stimulus
  int c, c2, c5;
  initial begin
    // Reset and boot table replay
    do_reset();
    wait_cyc(t0 + BOOT_DLY + 2 * NUM_INIT * (CMD_WAIT + 1) - 1);
    check("init_before", 64'(init_done_out), 64'd0);

    // Single command: requester 0 to DAC1
    wait_cyc(t0 + 30);
    c = cyc;
    dac1_rdata_in = 16'hBEEF;
    req0_in = 1'b1; addr0_in = 16'h0005; data0_in = 16'h1234; sel0_in = 1'b1;
    push_trig(c + 1, 2'b01, 1'b1, 16'h0005, 16'h1234);
    push_done(c + CMD_WAIT + 2, 1'b0, 16'hBEEF);
    wait_cyc(c + 1);
    req0_in = 1'b0;
    wait_cyc(c + 7);
    dac1_rdata_in = 16'h0000;
    wait_cyc(c + 8);
    check("rdata0_hold", 64'(rdata0_out), 64'h0000_BEEF);
    check("rdata1_keep", 64'(rdata1_out), 64'd0);

    // Contention: both held, grants alternate 0,1,0,1
    c2 = cyc;
    dac0_rdata_in = 16'h1111; dac1_rdata_in = 16'h2222;
    req0_in = 1'b1; addr0_in = 16'h0010; data0_in = 16'hAAAA; sel0_in = 1'b0;
    req1_in = 1'b1; addr1_in = 16'h0020; data1_in = 16'h5555; sel1_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_trig(c2 + 1 + k * (CMD_WAIT + 3), 2'b01, 1'b0, 16'h0010, 16'hAAAA);
        push_done(c2 + 1 + k * (CMD_WAIT + 3) + CMD_WAIT + 1, 1'b0, 16'h1111);
      end else begin
        push_trig(c2 + 1 + k * (CMD_WAIT + 3), 2'b10, 1'b1, 16'h0020, 16'h5555);
        push_done(c2 + 1 + k * (CMD_WAIT + 3) + CMD_WAIT + 1, 1'b1, 16'h2222);
      end
    end
    wait_cyc(c2 + 23);
    req0_in = 1'b0; req1_in = 1'b0;

    // Early request during BOOT is held until boot completes
    wait_cyc(c2 + 30);
    do_reset();
    wait_cyc(t0 + 3);
    dac0_rdata_in = 16'h3333;
    req1_in = 1'b1; addr1_in = 16'h0030; data1_in = 16'h0042; sel1_in = 1'b0;
    push_trig(t0 + 29, 2'b10, 1'b0, 16'h0030, 16'h0042);
    push_done(t0 + 29 + CMD_WAIT + 1, 1'b1, 16'h3333);
    wait_cyc(t0 + 29);
    req1_in = 1'b0;

    // Reset mid-command: no done, boot replays from entry 0
    wait_cyc(t0 + 36);
    c5 = cyc;
    req0_in = 1'b1; addr0_in = 16'h0040; data0_in = 16'h0077; sel0_in = 1'b1;
    push_trig(c5 + 1, 2'b01, 1'b1, 16'h0040, 16'h0077);
    wait_cyc(c5 + 1);
    req0_in = 1'b0;
    wait_cyc(c5 + 3);
    do_reset();
    wait_cyc(t0 + 40);

    check("trig_q_left", 64'(trig_q.size()), 64'd0);
    check("done_q_left", 64'(done_q.size()), 64'd0);
    check("init_q_left", 64'(init_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
